// File: rtl/servo_pwm_multi.sv
// rtl/servo_pwm_multi.sv - multi-channel servo PWM with clamped, frame-synchronous pulse widths
// Optional feature macro: SERVO_SLEW_EN (limit per-frame change of each active width to SLEW_STEP)
module servo_pwm_multi #(
   parameter int            NCH       = 4,
   parameter int            CW        = 16,
   parameter int            DIV       = 6,
   parameter logic [CW-1:0] PERIOD    = 16'hFFFF,
   parameter logic [CW-1:0] PW_MIN    = 16'h0510,
   parameter logic [CW-1:0] PW_MAX    = 16'h1A24,
   parameter logic [CW-1:0] SLEW_STEP = 16'h0010,
   parameter int            CHW       = (NCH > 1) ? $clog2(NCH) : 1
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           wr_en,
   input  logic [CHW-1:0] wr_ch,
   input  logic [CW-1:0]  wr_pw,
   output logic [NCH-1:0] pwm,
   output logic           frame_pulse,
   output logic           tick
);

   localparam int PSW = (DIV > 0) ? $clog2(DIV + 1) : 1;
   localparam logic [PSW-1:0] DIV_TC = PSW'(DIV);

`ifdef SERVO_SLEW_EN
   localparam bit SLEW_EN = 1'b1;
`else
   localparam bit SLEW_EN = 1'b0;
`endif

   // Without slew limiting the step is the full value range, so act always lands on target.
   localparam logic [CW-1:0] STEP = SLEW_EN ? SLEW_STEP : {CW{1'b1}};

   logic [PSW-1:0] presc;
   logic [CW-1:0]  fcnt;
   logic [CW-1:0]  target [NCH];
   logic [CW-1:0]  act    [NCH];
   logic           wrap;

   assign wrap = tick && (fcnt == PERIOD);

   function automatic logic [CW-1:0] clamp(input logic [CW-1:0] x);
      logic [CW-1:0] r;
      if (x == '0)
         r = '0;
      else if (x < PW_MIN)
         r = PW_MIN;
      else if (x > PW_MAX)
         r = PW_MAX;
      else
         r = x;
      return r;
   endfunction

   // Off->on and on->off transitions are immediate; otherwise move by at most STEP.
   function automatic logic [CW-1:0] next_act(input logic [CW-1:0] a, input logic [CW-1:0] t);
      logic [CW-1:0] r;
      if (t == '0 || a == '0)
         r = t;
      else if (t > a)
         r = ((t - a) <= STEP) ? t : a + STEP;
      else
         r = ((a - t) <= STEP) ? t : a - STEP;
      return r;
   endfunction

   always_ff @(posedge clk) begin
      if (reset) begin
         presc       <= '0;
         tick        <= 1'b0;
         fcnt        <= '0;
         frame_pulse <= 1'b0;
         pwm         <= '0;
         for (int i = 0; i < NCH; i++) begin
            target[i] <= '0;
            act[i]    <= '0;
         end
      end else begin
         presc       <= (presc == DIV_TC) ? '0 : presc + 1'b1;
         tick        <= (presc == DIV_TC);
         frame_pulse <= wrap;
         if (tick)
            fcnt <= (fcnt == PERIOD) ? '0 : fcnt + 1'b1;
         for (int i = 0; i < NCH; i++) begin
            pwm[i] <= (fcnt < act[i]);
            if (wrap)
               act[i] <= next_act(act[i], target[i]);
            if (wr_en && (wr_ch == CHW'(i)))
               target[i] <= clamp(wr_pw);
         end
      end
   end

endmodule

// File: tb/tb_servo_pwm_multi.sv
// tb/tb_servo_pwm_multi.sv - randomized and directed check of servo_pwm_multi against a frame-level model
module tb_servo_pwm_multi;

   localparam int NCH = 3;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       wr_en = 1'b0;
   logic [1:0] wr_ch = '0;
   logic [15:0] wr_pw = '0;
   logic [2:0] pwm;
   logic       frame_pulse;
   logic       tick;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   servo_pwm_multi #(
      .NCH(3), .CW(16), .DIV(1), .PERIOD(16'd99),
      .PW_MIN(16'd10), .PW_MAX(16'd90), .SLEW_STEP(16'd8)
   ) dut (
      .clk(clk), .reset(reset), .wr_en(wr_en), .wr_ch(wr_ch), .wr_pw(wr_pw),
      .pwm(pwm), .frame_pulse(frame_pulse), .tick(tick)
   );

   // Model: n = clock edges since reset; a tick every 2nd clock, fcnt follows the tick by one edge.
   int   n = 0;
   int   m_tgt [NCH];
   int   m_act [NCH];
   logic [2:0] e_pwm = '0;
   logic e_fp = 1'b0;
   logic e_tick = 1'b0;
   bit   chk = 1'b0;
   int   cnt [NCH];
   int   wk;

   function automatic int ticks_at(int k);
      return (k >= 1) ? (k - 1) / 2 : 0;
   endfunction

   function automatic int clampf(int x);
      if (x == 0) return 0;
      if (x < 10) return 10;
      if (x > 90) return 90;
      return x;
   endfunction

   function automatic int slewf(int a, int t);
`ifdef SERVO_SLEW_EN
      if (t == 0 || a == 0) return t;
      if (t > a) return (t - a <= 8) ? t : a + 8;
      return (a - t <= 8) ? t : a - 8;
`else
      return t;
`endif
   endfunction

   task automatic model_edge(bit r, bit we, int ch, int pw);
      int  fold;
      bit  fr;
      if (r) begin
         n = 0;
         for (int i = 0; i < NCH; i++) begin
            m_tgt[i] = 0;
            m_act[i] = 0;
         end
         e_pwm = '0;
         e_fp = 1'b0;
         e_tick = 1'b0;
      end else begin
         fold = ticks_at(n) % 100;
         n++;
         for (int i = 0; i < NCH; i++) e_pwm[i] = (fold < m_act[i]);
         fr = (n % 2 == 1) && (n >= 3) && (ticks_at(n) % 100 == 0);
         e_tick = (n % 2 == 0) && (n >= 2);
         e_fp = fr;
         if (fr)
            for (int i = 0; i < NCH; i++) m_act[i] = slewf(m_act[i], m_tgt[i]);
         if (we && ch < NCH) m_tgt[ch] = clampf(pw);
      end
   endtask

   always @(negedge clk) begin
      if (chk) begin
         n_cmp++;
         if (pwm !== e_pwm) begin
            n_bad++;
            $display("FAIL pwm got %b expected %b (n=%0d)", pwm, e_pwm, n);
         end
         n_cmp++;
         if (frame_pulse !== e_fp) begin
            n_bad++;
            $display("FAIL frame_pulse got %b expected %b (n=%0d)", frame_pulse, e_fp, n);
         end
         n_cmp++;
         if (tick !== e_tick) begin
            n_bad++;
            $display("FAIL tick got %b expected %b (n=%0d)", tick, e_tick, n);
         end
      end
   end

   task automatic check(string nm, int got, int exp);
      n_cmp++;
      if (got != exp) begin
         n_bad++;
         $display("FAIL %s got %0d expected %0d", nm, got, exp);
      end
   endtask

   task automatic step();
      bit r;
      bit we;
      int c;
      int p;
      r = reset;
      we = wr_en;
      c = int'(wr_ch);
      p = int'(wr_pw);
      @(posedge clk);
      model_edge(r, we, c, p);
      #1;
      wr_en = 1'b0;
   endtask

   task automatic wr(int ch, int pw);
      wr_en = 1'b1;
      wr_ch = 2'(ch);
      wr_pw = 16'(pw);
      step();
   endtask

   task automatic wait_fp(output int k);
      k = 0;
      do begin
         step();
         k++;
      end while (frame_pulse !== 1'b1 && k < 500);
      if (frame_pulse !== 1'b1) check("wait_fp_timeout", 0, 1);
   endtask

   task automatic measure();
      for (int i = 0; i < NCH; i++) cnt[i] = 0;
      repeat (200) begin
         step();
         for (int i = 0; i < NCH; i++) if (pwm[i] === 1'b1) cnt[i]++;
      end
   endtask

   int exp_s [5];
   int tcnt;

   initial begin
`ifdef SERVO_SLEW_EN
      exp_s = '{56, 72, 88, 104, 120};
`else
      exp_s = '{120, 120, 120, 120, 120};
`endif
      reset = 1'b1;
      repeat (3) step();
      chk = 1'b1;
      check("rst_pwm0", int'(pwm), 0);
      check("rst_fp", int'(frame_pulse), 0);
      check("rst_tick", int'(tick), 0);
      reset = 1'b0;
      tcnt = 0;
      repeat (20) begin
         step();
         if (tick === 1'b1) tcnt++;
      end
      check("tick_rate", tcnt, 10);

      // Reset mid-frame while a channel is high.
      wr(0, 50);
      wait_fp(wk);
      repeat (20) step();
      check("pre_rst_pwm0", int'(pwm[0]), 1);
      reset = 1'b1;
      step();
      check("rst_mid_pwm", int'(pwm), 0);
      step();
      step();
      reset = 1'b0;
      wait_fp(wk);
      check("restart_len", wk, 201);

      repeat (37) step();
      wr(0, 25);
      wait_fp(wk);
      measure();
      check("ch0_25", cnt[0], 50);

      wr(1, 5);
      wait_fp(wk);
      measure();
      check("clamp_lo", cnt[1], 20);
      wr(1, 0);
      wait_fp(wk);
      measure();
      check("ch1_off", cnt[1], 0);
      wr(1, 95);
      wait_fp(wk);
      measure();
      check("clamp_hi", cnt[1], 180);

      // Write presented on the wrap edge lands one frame later.
      wr(2, 36);
      wait_fp(wk);
      repeat (199) step();
      wr(2, 40);
      check("wrap_sync", int'(frame_pulse), 1);
      measure();
      check("ch2_old", cnt[2], 72);
      measure();
      check("ch2_new", cnt[2], 80);

      wr(3, 50);
      wait_fp(wk);
      measure();
      check("bad_ch0", cnt[0], 50);
      check("bad_ch1", cnt[1], 180);
      check("bad_ch2", cnt[2], 80);

      wr(0, 30);
      wr(1, 85);
      wr(2, 34);
      wait_fp(wk);
      measure();
      check("multi_ch0", cnt[0], 60);
      check("multi_ch1", cnt[1], 170);
      check("multi_ch2", cnt[2], 68);

      wr(0, 0);
      wait_fp(wk);
      wr(0, 20);
      wait_fp(wk);
      measure();
      check("slew_start", cnt[0], 40);
      wr(0, 60);
      wait_fp(wk);
      for (int f = 0; f < 5; f++) begin
         measure();
         check($sformatf("slew_f%0d", f), cnt[0], exp_s[f]);
      end
      wr(0, 0);
      wait_fp(wk);
      measure();
      check("slew_off", cnt[0], 0);

      repeat (6000) begin
         if ($urandom_range(0, 999) == 0) begin
            reset = 1'b1;
            repeat ($urandom_range(1, 3)) step();
            reset = 1'b0;
         end
         if ($urandom_range(0, 3) == 0) begin
            wr_en = 1'b1;
            wr_ch = 2'($urandom_range(0, 3));
            wr_pw = 16'($urandom_range(0, 120));
         end
         step();
      end

      @(posedge clk);
      #1;
      chk = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
